// File: rtl/thresholding_axilite_loader_if.sv
// Bus bundle for the threshold loader: AXI-Stream threshold input plus AXI-Lite write-only initiator.
// master = loader side (stream sink, AXI-Lite initiator); slave = environment side.
interface thresholding_axilite_loader_if #(
   parameter int unsigned A_BITS  = 4,
   parameter int unsigned TDATA_W = 8
);
   logic               s_axis_tready;
   logic               s_axis_tvalid;
   logic [TDATA_W-1:0] s_axis_tdata;

   logic               m_axilite_AWVALID;
   logic               m_axilite_AWREADY;
   logic [A_BITS-1:0]  m_axilite_AWADDR;
   logic               m_axilite_WVALID;
   logic               m_axilite_WREADY;
   logic [31:0]        m_axilite_WDATA;
   logic [3:0]         m_axilite_WSTRB;
   logic               m_axilite_BVALID;
   logic               m_axilite_BREADY;
   logic [1:0]         m_axilite_BRESP;

   modport master (
      output s_axis_tready,
      input  s_axis_tvalid, s_axis_tdata,
      output m_axilite_AWVALID, m_axilite_AWADDR,
      input  m_axilite_AWREADY,
      output m_axilite_WVALID, m_axilite_WDATA, m_axilite_WSTRB,
      input  m_axilite_WREADY,
      input  m_axilite_BVALID, m_axilite_BRESP,
      output m_axilite_BREADY
   );

   modport slave (
      input  s_axis_tready,
      output s_axis_tvalid, s_axis_tdata,
      input  m_axilite_AWVALID, m_axilite_AWADDR,
      output m_axilite_AWREADY,
      input  m_axilite_WVALID, m_axilite_WDATA, m_axilite_WSTRB,
      output m_axilite_WREADY,
      output m_axilite_BVALID, m_axilite_BRESP,
      input  m_axilite_BREADY
   );
endinterface

// File: rtl/thresholding_axilite_loader.sv
// Streams channel-major thresholds into a thresholding core over AXI-Lite, one write outstanding.
// Address is {channel, index}; index 2^N-1 is never written.
module thresholding_axilite_loader #(
   parameter int unsigned N = 2,
   parameter int unsigned M = 8,
   parameter int unsigned C = 3
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   thresholding_axilite_loader_if.master bus
);
   localparam int unsigned A_BITS = $clog2(C) + N;
   localparam int unsigned CW     = (C > 1) ? $clog2(C) : 1;
   localparam logic [N-1:0]  T_LAST = N'((1 << N) - 2);
   localparam logic [CW-1:0] C_LAST = CW'(C - 1);

   typedef enum logic [1:0] {IDLE, FETCH, WRITE, RESP} state_e;

   state_e            state_q, state_d;
   logic [N-1:0]      t_q, t_d;
   logic [CW-1:0]     c_q, c_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              tready_q, tready_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic [A_BITS-1:0] awaddr_q, awaddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              last_c;

   assign last_c = (c_q == C_LAST) && (t_q == T_LAST);

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      c_d       = c_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      tready_d  = tready_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = FETCH;
               busy_d   = 1'b1;
               tready_d = 1'b1;
               t_d      = '0;
               c_d      = '0;
               err_d    = 1'b0;
            end
         end
         FETCH: begin
            if (bus.s_axis_tvalid) begin
               state_d   = WRITE;
               tready_d  = 1'b0;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               awaddr_d  = A_BITS'({c_q, t_q});
               wdata_d   = 32'(bus.s_axis_tdata[M-1:0]);
            end
         end
         WRITE: begin
            // AW and W retire independently; B is only accepted once both are gone
            if (bus.m_axilite_AWREADY) awvalid_d = 1'b0;
            if (bus.m_axilite_WREADY)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = RESP;
               bready_d = 1'b1;
            end
         end
         RESP: begin
            if (bus.m_axilite_BVALID) begin
               bready_d = 1'b0;
               if (bus.m_axilite_BRESP != 2'b00) err_d = 1'b1;
               if (last_c) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d  = FETCH;
                  tready_d = 1'b1;
                  if (t_q == T_LAST) begin
                     t_d = '0;
                     c_d = c_q + CW'(1);
                  end else begin
                     t_d = t_q + N'(1);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q   <= IDLE;
         t_q       <= '0;
         c_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         tready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         t_q       <= t_d;
         c_q       <= c_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         tready_q  <= tready_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign busy                  = busy_q;
   assign done                  = done_q;
   assign err                   = err_q;
   assign bus.s_axis_tready     = tready_q;
   assign bus.m_axilite_AWVALID = awvalid_q;
   assign bus.m_axilite_AWADDR  = awaddr_q;
   assign bus.m_axilite_WVALID  = wvalid_q;
   assign bus.m_axilite_WDATA   = wdata_q;
   assign bus.m_axilite_WSTRB   = 4'hF;
   assign bus.m_axilite_BREADY  = bready_q;
endmodule

// File: tb/tb_thresholding_axilite_loader.sv
// Scoreboard bench for thresholding_axilite_loader: a 3-channel N=2 instance against a
// configurable AXI-Lite slave model, plus a single-channel 32-bit instance against an always-ready slave.
module tb_thresholding_axilite_loader;
   localparam int unsigned N  = 2, M  = 8,  C  = 3;
   localparam int unsigned A_BITS = $clog2(C) + N;
   localparam int unsigned TW = ((M + 7) / 8) * 8;
   localparam int unsigned N2 = 3, M2 = 32, C2 = 1;
   localparam int unsigned A2  = $clog2(C2) + N2;
   localparam int unsigned TW2 = ((M2 + 7) / 8) * 8;
   localparam int NWR  = 9;
   localparam int NWR2 = 7;

   logic clk = 1'b0;
   logic rst;
   logic start, busy, done, err;
   logic start2, busy2, done2, err2;

   always #5 clk = ~clk;

   thresholding_axilite_loader_if #(.A_BITS(A_BITS), .TDATA_W(TW))  bus ();
   thresholding_axilite_loader_if #(.A_BITS(A2),     .TDATA_W(TW2)) bus2 ();

   thresholding_axilite_loader #(.N(N), .M(M), .C(C)) dut (
      .ap_clk(clk), .ap_rst(rst), .start(start), .busy(busy), .done(done), .err(err), .bus(bus.master)
   );

   thresholding_axilite_loader #(.N(N2), .M(M2), .C(C2)) dut2 (
      .ap_clk(clk), .ap_rst(rst), .start(start2), .busy(busy2), .done(done2), .err(err2), .bus(bus2.master)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave model configuration and state (state only written by the slave process)
   int aw_dly, w_dly, b_dly, bad_idx;
   int aw_wait, w_wait, b_wait;
   int aw_cnt, w_cnt, b_cnt, b_issued, done_cnt;
   bit aw_hs, w_hs, b_hs, exp_err, busy_prev;
   logic [A_BITS-1:0] aw_hold;
   logic [31:0]       w_hold;
   logic [A_BITS-1:0] exp_aw_q[$];
   logic [31:0]       exp_w_q[$];
   int exp_addr [NWR] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

   // Readies are decided on the falling edge; a valid seen with ready set here completes at the next rising edge
   always @(negedge clk) begin
      if (rst) begin
         bus.m_axilite_AWREADY = 1'b0;
         bus.m_axilite_WREADY  = 1'b0;
         bus.m_axilite_BVALID  = 1'b0;
         bus.m_axilite_BRESP   = 2'b00;
         aw_wait = 0; w_wait = 0; b_wait = 0;
         aw_hs = 0; w_hs = 0; b_hs = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_issued = 0; done_cnt = 0;
         exp_err = 0; busy_prev = 0;
         exp_aw_q.delete();
         exp_w_q.delete();
      end else begin
         if (busy && !busy_prev) begin
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_issued = 0; done_cnt = 0; exp_err = 0;
            check("err_clear_on_start", err, 0);
         end
         busy_prev = busy;

         if (aw_hs) begin
            bus.m_axilite_AWREADY = 1'b0;
            aw_hs = 0;
            aw_cnt++;
            check("awvalid_drop", bus.m_axilite_AWVALID, 0);
         end else if (bus.m_axilite_AWVALID) begin
            if (aw_wait == 0) aw_hold = bus.m_axilite_AWADDR;
            else check("awaddr_stable", bus.m_axilite_AWADDR, aw_hold);
            if (aw_wait >= aw_dly) begin
               bus.m_axilite_AWREADY = 1'b1;
               aw_hs = 1; aw_wait = 0;
               if (exp_aw_q.size() == 0) begin
                  n_vec++; n_miss++;
                  $display("FAIL aw_extra: unexpected write to 0x%0h", bus.m_axilite_AWADDR);
               end else check("awaddr", bus.m_axilite_AWADDR, exp_aw_q.pop_front());
            end else aw_wait++;
         end else if (aw_wait > 0) begin
            check("awvalid_held", bus.m_axilite_AWVALID, 1);
            aw_wait = 0;
         end

         if (w_hs) begin
            bus.m_axilite_WREADY = 1'b0;
            w_hs = 0;
            w_cnt++;
            check("wvalid_drop", bus.m_axilite_WVALID, 0);
         end else if (bus.m_axilite_WVALID) begin
            if (w_wait == 0) w_hold = bus.m_axilite_WDATA;
            else check("wdata_stable", bus.m_axilite_WDATA, w_hold);
            if (w_wait >= w_dly) begin
               bus.m_axilite_WREADY = 1'b1;
               w_hs = 1; w_wait = 0;
               check("wstrb", bus.m_axilite_WSTRB, 4'hF);
               if (exp_w_q.size() == 0) begin
                  n_vec++; n_miss++;
                  $display("FAIL w_extra: unexpected data 0x%0h", bus.m_axilite_WDATA);
               end else check("wdata", bus.m_axilite_WDATA, exp_w_q.pop_front());
            end else w_wait++;
         end else if (w_wait > 0) begin
            check("wvalid_held", bus.m_axilite_WVALID, 1);
            w_wait = 0;
         end

         if (b_hs) begin
            bus.m_axilite_BVALID = 1'b0;
            b_hs = 0;
            b_cnt++;
            if (bus.m_axilite_BRESP != 2'b00) exp_err = 1;
            check("bready_drop", bus.m_axilite_BREADY, 0);
            check("err", err, exp_err);
            check("done_on_last", done, b_cnt == NWR);
         end else begin
            if (bus.m_axilite_BREADY)
               check("bready_after_aw_w", (aw_cnt > b_cnt) && (w_cnt > b_cnt), 1);
            if (!bus.m_axilite_BVALID && aw_cnt > b_issued && w_cnt > b_issued) begin
               if (b_wait >= b_dly) begin
                  bus.m_axilite_BVALID = 1'b1;
                  bus.m_axilite_BRESP  = (b_issued == bad_idx) ? 2'b10 : 2'b00;
                  b_issued++;
                  b_wait = 0;
               end else b_wait++;
            end
            if (bus.m_axilite_BVALID && bus.m_axilite_BREADY) b_hs = 1;
         end

         if (done) done_cnt++;
      end
   end

   // Single-channel instance: always-ready slave and an always-valid all-ones stream
   logic [A2-1:0] exp2_aw_q[$];
   logic [31:0]   exp2_w_q[$];
   int done2_cnt = 0;
   int b2_cnt    = 0;

   assign bus2.m_axilite_AWREADY = 1'b1;
   assign bus2.m_axilite_WREADY  = 1'b1;
   assign bus2.m_axilite_BVALID  = 1'b1;
   assign bus2.m_axilite_BRESP   = 2'b00;
   assign bus2.s_axis_tvalid     = 1'b1;
   assign bus2.s_axis_tdata      = 32'hFFFF_FFFF;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus2.m_axilite_AWVALID) begin
            if (exp2_aw_q.size() == 0) begin
               n_vec++; n_miss++;
               $display("FAIL c1_aw_extra: unexpected write to 0x%0h", bus2.m_axilite_AWADDR);
            end else check("c1_awaddr", bus2.m_axilite_AWADDR, exp2_aw_q.pop_front());
         end
         if (bus2.m_axilite_WVALID) begin
            if (exp2_w_q.size() == 0) begin
               n_vec++; n_miss++;
               $display("FAIL c1_w_extra: unexpected data 0x%0h", bus2.m_axilite_WDATA);
            end else check("c1_wdata", bus2.m_axilite_WDATA, exp2_w_q.pop_front());
         end
         if (bus2.m_axilite_BREADY) b2_cnt++;
         if (done2) done2_cnt++;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_busy"},    busy, 0);
      check({tag, "_done"},    done, 0);
      check({tag, "_err"},     err, 0);
      check({tag, "_tready"},  bus.s_axis_tready, 0);
      check({tag, "_awvalid"}, bus.m_axilite_AWVALID, 0);
      check({tag, "_wvalid"},  bus.m_axilite_WVALID, 0);
      check({tag, "_bready"},  bus.m_axilite_BREADY, 0);
      check({tag, "_awaddr"},  bus.m_axilite_AWADDR, 0);
      check({tag, "_wdata"},   bus.m_axilite_WDATA, 0);
      check({tag, "_wstrb"},   bus.m_axilite_WSTRB, 4'hF);
   endtask

   task automatic drive_beats(input int n, input bit gaps, input bit restart);
      int g;
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom_range(0, 3)) step();
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tdata  = TW'(32'h10 + i);
         g = 0;
         while (!bus.s_axis_tready && g < 200) begin
            step();
            g++;
         end
         check("tready_wait", bus.s_axis_tready, 1);
         exp_aw_q.push_back(A_BITS'(exp_addr[i]));
         exp_w_q.push_back(32'(32'h10 + i));
         if (restart && i == 4) start = 1'b1;
         step();
         start = 1'b0;
         bus.s_axis_tvalid = 1'b0;
      end
   endtask

   task automatic run_load(input bit gaps, input bit restart, input bit err_end);
      int g;
      int seen;
      start = 1'b1;
      step();
      start = 1'b0;
      check("busy_on_start", busy, 1);
      check("tready_on_start", bus.s_axis_tready, 1);
      drive_beats(NWR, gaps, restart);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = TW'(8'h99);
      seen = 0;
      g = 0;
      while (done_cnt == 0 && g < 300) begin
         step();
         g++;
         if (bus.s_axis_tready) seen++;
      end
      repeat (3) begin
         step();
         if (bus.s_axis_tready) seen++;
      end
      bus.s_axis_tvalid = 1'b0;
      check("done_pulses", done_cnt, 1);
      check("busy_end", busy, 0);
      check("err_end", err, err_end);
      check("aw_count", aw_cnt, NWR);
      check("w_count", w_cnt, NWR);
      check("b_count", b_cnt, NWR);
      check("extra_beat_taken", seen, 0);
      check("aw_left", exp_aw_q.size(), 0);
      check("w_left", exp_w_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      rst = 1'b1;
      start = 1'b0;
      start2 = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
      aw_dly = 0; w_dly = 0; b_dly = 0; bad_idx = -1;
      repeat (2) step();
      check_reset("por");
      check("c1_busy_rst", busy2, 0);
      check("c1_awvalid_rst", bus2.m_axilite_AWVALID, 0);
      rst = 1'b0;
      step();

      run_load(0, 0, 0);
      aw_dly = 3;
      run_load(0, 0, 0);
      aw_dly = 0; w_dly = 3;
      run_load(0, 0, 0);
      w_dly = 0; bad_idx = 3;
      run_load(0, 0, 1);
      bad_idx = -1;
      run_load(0, 0, 0);
      b_dly = 5;
      run_load(1, 1, 0);

      // Asynchronous reset while write 5 is waiting on AWREADY
      b_dly = 0; aw_dly = 3;
      start = 1'b1;
      step();
      start = 1'b0;
      drive_beats(5, 0, 0);
      check("mid_awvalid", bus.m_axilite_AWVALID, 1);
      check("mid_awaddr", bus.m_axilite_AWADDR, 5);
      rst = 1'b1;
      #1;
      check_reset("async");
      step();
      rst = 1'b0;
      aw_dly = 0;
      step();
      run_load(0, 0, 0);

      for (int i = 0; i < NWR2; i++) begin
         exp2_aw_q.push_back(A2'(i));
         exp2_w_q.push_back(32'hFFFF_FFFF);
      end
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      check("c1_busy_on_start", busy2, 1);
      g = 0;
      while (done2_cnt == 0 && g < 300) begin
         step();
         g++;
      end
      repeat (3) step();
      check("c1_done_pulses", done2_cnt, 1);
      check("c1_b_count", b2_cnt, NWR2);
      check("c1_busy_end", busy2, 0);
      check("c1_tready_end", bus2.s_axis_tready, 0);
      check("c1_err_end", err2, 0);
      check("c1_aw_left", exp2_aw_q.size(), 0);
      check("c1_w_left", exp2_w_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
